// File: rtl/iobuf_bank.sv
// Registered bidirectional pad bank: shared direction control, IOB-style output, tristate and
// input registers, plus a turnaround FSM that enforces hi-Z cycles between release and re-drive.
module iobuf_bank #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned IN_STAGES    = 2,
  parameter int unsigned TURNAROUND   = 2,
  parameter              IOSTANDARD   = "default",
  parameter int unsigned DRIVE        = 12,
  parameter              SLEW         = "SLOW",
  parameter              IO_LOC_PAIRS = ""
) (
  input  logic             C,
  input  logic             CLR,
  inout  wire  [WIDTH-1:0] IO,
  input  logic [WIDTH-1:0] I,
  input  logic             CE,
  input  logic             T_REQ,
  output logic [WIDTH-1:0] O,
  output logic             DRV,
  output logic             BUSY
);

  if (WIDTH < 1 || WIDTH > 64) begin : gen_bad_width
    $error("iobuf_bank: WIDTH must be 1..64");
  end
  if (IN_STAGES < 1 || IN_STAGES > 4) begin : gen_bad_in_stages
    $error("iobuf_bank: IN_STAGES must be 1..4");
  end
  if (TURNAROUND > 15) begin : gen_bad_turnaround
    $error("iobuf_bank: TURNAROUND must be 0..15");
  end
  if (DRIVE == 0) begin : gen_bad_drive
    $error("iobuf_bank: DRIVE must be non-zero");
  end
  if (SLEW != "SLOW" && SLEW != "FAST") begin : gen_bad_slew
    $error("iobuf_bank: SLEW must be SLOW or FAST");
  end
  if (IOSTANDARD == "") begin : gen_bad_iostandard
    $error("iobuf_bank: IOSTANDARD must not be empty");
  end
  if (IO_LOC_PAIRS == "?") begin : gen_bad_loc_pairs
    $error("iobuf_bank: IO_LOC_PAIRS is malformed");
  end

  typedef enum logic [1:0] {StHiz, StDrive, StTurn} state_e;

  localparam logic [3:0] TurnLoad = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             tq_q, tq_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] dq_q;
  logic [WIDTH-1:0] in_q [IN_STAGES];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StHiz: begin
        if (!T_REQ) state_d = StDrive;
      end
      StDrive: begin
        if (T_REQ) begin
          if (TURNAROUND == 0) begin
            state_d = StHiz;
          end else begin
            state_d = StTurn;
            cnt_d   = TurnLoad;
          end
        end
      end
      StTurn: begin
        // T_REQ is deliberately ignored until the hi-Z window has elapsed.
        if (cnt_q == 4'd0) begin
          state_d = StHiz;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StHiz;
        cnt_d   = 4'd0;
      end
    endcase
    tq_d   = (state_d != StDrive);
    busy_d = (state_d == StTurn);
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q <= StHiz;
      cnt_q   <= 4'd0;
      tq_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tq_q    <= tq_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      dq_q <= '0;
    end else if (CE) begin
      dq_q <= I;
    end
  end

  // Input chain samples the pad itself, so O reads back our own drive too.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      for (int s = 0; s < IN_STAGES; s++) in_q[s] <= '0;
    end else begin
      in_q[0] <= IO;
      for (int s = 1; s < IN_STAGES; s++) in_q[s] <= in_q[s-1];
    end
  end

  assign IO   = tq_q ? {WIDTH{1'bz}} : dq_q;
  assign O    = in_q[IN_STAGES-1];
  assign DRV  = ~tq_q;
  assign BUSY = busy_q;

endmodule
